rv_instr_fields: RTL and testbench

- Registered RV32I instruction field extractor with 12→32 sign extension of the I-type and S-type immediates.
- Sits between the instruction fetch register and the decoder/control logic.
- Gives the decoder stable, pre-split fields one cycle after the instruction is presented.

---
 rtl/rv_instr_fields_pkg.sv | 67 ++++++
 rtl/rv_instr_fields_sign_extend.sv | 16 +
 rtl/rv_instr_fields.sv | 101 ++++++++++
 tb/tb_rv_instr_fields.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/rv_instr_fields_pkg.sv
// Shared RV32I field layout, opcode map and field-split helper for the fetch/decode boundary.
// Used by rv_instr_fields (optional B-type immediate under RV_BIMM_EN) and the decoder.
package rv_instr_fields_pkg;

  localparam int INSTR_W    = 32;

  localparam int OPCODE_LSB = 0;
  localparam int RD_LSB     = 7;
  localparam int FUNCT3_LSB = 12;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 20;
  localparam int FUNCT7_LSB = 25;
  localparam int IMM20_LSB  = 12;
  localparam int IMM12_LSB  = 20;

  localparam int OPCODE_W   = 7;
  localparam int REG_W      = 5;
  localparam int FUNCT3_W   = 3;
  localparam int FUNCT7_W   = 7;
  localparam int IMM20_W    = 20;
  localparam int IMM12_W    = 12;
  localparam int IMM13B_W   = 13;

  typedef enum logic [OPCODE_W-1:0] {
    OP_LOAD    = 7'h03,
    OP_MISCMEM = 7'h0F,
    OP_OPIMM   = 7'h13,
    OP_AUIPC   = 7'h17,
    OP_STORE   = 7'h23,
    OP_OP      = 7'h33,
    OP_LUI     = 7'h37,
    OP_BRANCH  = 7'h63,
    OP_JALR    = 7'h67,
    OP_JAL     = 7'h6F,
    OP_SYSTEM  = 7'h73
  } opcode_e;

  typedef struct packed {
    logic [REG_W-1:0]    rs1;
    logic [REG_W-1:0]    rs2;
    logic [REG_W-1:0]    rd;
    logic [OPCODE_W-1:0] opCode;
    logic [FUNCT3_W-1:0] funct3;
    logic [FUNCT7_W-1:0] funct7;
    logic [IMM20_W-1:0]  imm20;
    logic [IMM12_W-1:0]  imm12;
    logic [IMM12_W-1:0]  imm12S;
    logic [IMM13B_W-1:0] imm13B;
  } instrFields_t;

  // Pure bit slicing; opcode is never consulted, so illegal encodings split the same way.
  function automatic instrFields_t extractFields(input logic [INSTR_W-1:0] instr);
    instrFields_t f;
    f.rs1    = instr[RS1_LSB    +: REG_W];
    f.rs2    = instr[RS2_LSB    +: REG_W];
    f.rd     = instr[RD_LSB     +: REG_W];
    f.opCode = instr[OPCODE_LSB +: OPCODE_W];
    f.funct3 = instr[FUNCT3_LSB +: FUNCT3_W];
    f.funct7 = instr[FUNCT7_LSB +: FUNCT7_W];
    f.imm20  = instr[IMM20_LSB  +: IMM20_W];
    f.imm12  = instr[IMM12_LSB  +: IMM12_W];
    f.imm12S = {instr[FUNCT7_LSB +: FUNCT7_W], instr[RD_LSB +: REG_W]};
    f.imm13B = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    return f;
  endfunction

endpackage

// File: rtl/rv_instr_fields_sign_extend.sv
// Combinational sign extension of an IN_W-bit field to XLEN bits (MSB replication only).
module rv_sign_extend #(
  parameter int IN_W = 12,
  parameter int XLEN = 32
) (
  input  logic [IN_W-1:0] value,
  output logic [XLEN-1:0] extended
);

  if (XLEN > IN_W) begin : gExt
    assign extended = {{(XLEN-IN_W){value[IN_W-1]}}, value};
  end else begin : gSame
    assign extended = value[XLEN-1:0];
  end

endmodule

// File: rtl/rv_instr_fields.sv
// Registered RV32I field extractor: one-cycle split of the fetched word plus I/S immediates
// sign-extended to XLEN. Define RV_BIMM_EN to add the B-type immediate outputs.
module rv_instr_fields
  import rv_instr_fields_pkg::*;
#(
  parameter int XLEN = 32  // must be >= 13
) (
  input  logic                 iwClk,
  input  logic                 iwRst,
  input  logic                 iwEn,
  input  logic [INSTR_W-1:0]   iwInstr,
  output logic [REG_W-1:0]     orRs1,
  output logic [REG_W-1:0]     orRs2,
  output logic [REG_W-1:0]     orRd,
  output logic [OPCODE_W-1:0]  orOpCode,
  output logic [FUNCT3_W-1:0]  orFunct3,
  output logic [FUNCT7_W-1:0]  orFunct7,
  output logic [IMM20_W-1:0]   orImm20,
  output logic [IMM12_W-1:0]   orImm12,
  output logic [IMM12_W-1:0]   orImm12S,
  output logic [XLEN-1:0]      orImm12Ext,
  output logic [XLEN-1:0]      orImm12SExt,
  output logic                 orValid
`ifdef RV_BIMM_EN
  ,
  output logic [IMM13B_W-1:0]  orImm13B,
  output logic [XLEN-1:0]      orImm13BExt
`endif
);

  instrFields_t fields;
  logic [XLEN-1:0] imm12Ext;
  logic [XLEN-1:0] imm12SExt;

  assign fields = extractFields(iwInstr);

  // Extension works on the incoming word so the Ext outputs land in the same cycle as the fields.
  rv_sign_extend #(.IN_W(IMM12_W), .XLEN(XLEN)) uExtI (
    .value    (fields.imm12),
    .extended (imm12Ext)
  );

  rv_sign_extend #(.IN_W(IMM12_W), .XLEN(XLEN)) uExtS (
    .value    (fields.imm12S),
    .extended (imm12SExt)
  );

  always_ff @(posedge iwClk or posedge iwRst) begin
    if (iwRst) begin
      orRs1       <= '0;
      orRs2       <= '0;
      orRd        <= '0;
      orOpCode    <= '0;
      orFunct3    <= '0;
      orFunct7    <= '0;
      orImm20     <= '0;
      orImm12     <= '0;
      orImm12S    <= '0;
      orImm12Ext  <= '0;
      orImm12SExt <= '0;
      orValid     <= 1'b0;
    end else if (iwEn) begin
      orRs1       <= fields.rs1;
      orRs2       <= fields.rs2;
      orRd        <= fields.rd;
      orOpCode    <= fields.opCode;
      orFunct3    <= fields.funct3;
      orFunct7    <= fields.funct7;
      orImm20     <= fields.imm20;
      orImm12     <= fields.imm12;
      orImm12S    <= fields.imm12S;
      orImm12Ext  <= imm12Ext;
      orImm12SExt <= imm12SExt;
      orValid     <= 1'b1;
    end
  end

`ifdef RV_BIMM_EN
  logic [XLEN-1:0] imm13BExt;

  rv_sign_extend #(.IN_W(IMM13B_W), .XLEN(XLEN)) uExtB (
    .value    (fields.imm13B),
    .extended (imm13BExt)
  );

  always_ff @(posedge iwClk or posedge iwRst) begin
    if (iwRst) begin
      orImm13B    <= '0;
      orImm13BExt <= '0;
    end else if (iwEn) begin
      orImm13B    <= fields.imm13B;
      orImm13BExt <= imm13BExt;
    end
  end
`else
  // imm13B is only consumed when the branch-immediate outputs are built.
  logic unusedImm13B;
  assign unusedImm13B = ^fields.imm13B;
`endif

endmodule

// File: tb/tb_rv_instr_fields.sv
// Directed-vector bench for rv_instr_fields; expected values are hand-decoded encodings.
module tb_rv_instr_fields;

  localparam int XLEN = 32;

  logic            iwClk = 1'b0;
  logic            iwRst;
  logic            iwEn;
  logic [31:0]     iwInstr;
  logic [4:0]      orRs1, orRs2, orRd;
  logic [6:0]      orOpCode, orFunct7;
  logic [2:0]      orFunct3;
  logic [19:0]     orImm20;
  logic [11:0]     orImm12, orImm12S;
  logic [XLEN-1:0] orImm12Ext, orImm12SExt;
  logic            orValid;
`ifdef RV_BIMM_EN
  logic [12:0]     orImm13B;
  logic [XLEN-1:0] orImm13BExt;
`endif

  int nTests = 0;
  int nFail  = 0;

  always #5 iwClk = ~iwClk;

  rv_instr_fields #(.XLEN(XLEN)) dut (
    .iwClk       (iwClk),
    .iwRst       (iwRst),
    .iwEn        (iwEn),
    .iwInstr     (iwInstr),
    .orRs1       (orRs1),
    .orRs2       (orRs2),
    .orRd        (orRd),
    .orOpCode    (orOpCode),
    .orFunct3    (orFunct3),
    .orFunct7    (orFunct7),
    .orImm20     (orImm20),
    .orImm12     (orImm12),
    .orImm12S    (orImm12S),
    .orImm12Ext  (orImm12Ext),
    .orImm12SExt (orImm12SExt),
    .orValid     (orValid)
`ifdef RV_BIMM_EN
    ,
    .orImm13B    (orImm13B),
    .orImm13BExt (orImm13BExt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present a word with the given enable, advance one edge, sample 1ns later.
  task automatic step(input logic [31:0] instr, input logic en);
    iwInstr = instr;
    iwEn    = en;
    @(posedge iwClk);
    #1;
  endtask

  initial begin
    iwRst = 1'b1; iwEn = 1'b0; iwInstr = 32'h0;
    #12;
    chk("rst.valid",    32'(orValid),    32'h0);
    chk("rst.rd",       32'(orRd),       32'h0);
    chk("rst.opcode",   32'(orOpCode),   32'h0);
    chk("rst.imm12Ext", orImm12Ext,      32'h0);
    iwRst = 1'b0;

    step(32'hFFF1_0093, 1'b0);  // enable low after reset: nothing captured
    chk("noen.valid", 32'(orValid), 32'h0);
    chk("noen.rd",    32'(orRd),    32'h0);

    step(32'hFFF1_0093, 1'b1);  // addi x1,x2,-1
    chk("addi.rd",       32'(orRd),     32'd1);
    chk("addi.rs1",      32'(orRs1),    32'd2);
    chk("addi.opcode",   32'(orOpCode), 32'h13);
    chk("addi.funct3",   32'(orFunct3), 32'h0);
    chk("addi.imm12",    32'(orImm12),  32'hFFF);
    chk("addi.imm12Ext", orImm12Ext,    32'hFFFF_FFFF);
    chk("addi.valid",    32'(orValid),  32'h1);

    step(32'h0053_2423, 1'b1);  // sw x5,8(x6)
    chk("sw.rs1",       32'(orRs1),    32'd6);
    chk("sw.rs2",       32'(orRs2),    32'd5);
    chk("sw.funct3",    32'(orFunct3), 32'd2);
    chk("sw.opcode",    32'(orOpCode), 32'h23);
    chk("sw.imm12S",    32'(orImm12S), 32'h008);
    chk("sw.imm12SExt", orImm12SExt,   32'h0000_0008);
    chk("sw.imm12",     32'(orImm12),  32'h005);

    step(32'h4031_00B3, 1'b1);  // sub x1,x2,x3
    chk("sub.funct7", 32'(orFunct7), 32'h20);
    chk("sub.rs2",    32'(orRs2),    32'd3);
    chk("sub.rs1",    32'(orRs1),    32'd2);
    chk("sub.rd",     32'(orRd),     32'd1);
    chk("sub.opcode", 32'(orOpCode), 32'h33);

    step(32'h1234_51B7, 1'b1);  // lui x3,0x12345
    chk("lui.imm20",  32'(orImm20),  32'h12345);
    chk("lui.rd",     32'(orRd),     32'd3);
    chk("lui.opcode", 32'(orOpCode), 32'h37);

    step(32'h7FF0_0013, 1'b1);
    chk("imax.imm12Ext", orImm12Ext, 32'h0000_07FF);
    step(32'h7E00_0FA3, 1'b1);
    chk("smax.imm12S",    32'(orImm12S), 32'h7FF);
    chk("smax.imm12SExt", orImm12SExt,   32'h0000_07FF);
    step(32'h8000_0013, 1'b1);
    chk("imin.imm12Ext",  orImm12Ext,  32'hFFFF_F800);
    chk("imin.imm12SExt", orImm12SExt, 32'hFFFF_F800);

    for (int i = 0; i < 3; i++) begin
      step(32'h1234_5678 + 32'(i), 1'b0);
      chk("hold.imm12Ext", orImm12Ext,    32'hFFFF_F800);
      chk("hold.opcode",   32'(orOpCode), 32'h13);
      chk("hold.imm20",    32'(orImm20),  32'h80000);
      chk("hold.valid",    32'(orValid),  32'h1);
    end

    // Asynchronous reset between edges, then capture on the first edge after release.
    #2 iwRst = 1'b1;
    #1;
    chk("arst.valid",     32'(orValid),  32'h0);
    chk("arst.opcode",    32'(orOpCode), 32'h0);
    chk("arst.imm20",     32'(orImm20),  32'h0);
    chk("arst.imm12Ext",  orImm12Ext,    32'h0);
    chk("arst.imm12SExt", orImm12SExt,   32'h0);
    #1 iwRst = 1'b0;
    step(32'hFFF1_0093, 1'b1);
    chk("rel.rd",       32'(orRd),     32'd1);
    chk("rel.rs1",      32'(orRs1),    32'd2);
    chk("rel.imm12Ext", orImm12Ext,    32'hFFFF_FFFF);
    chk("rel.valid",    32'(orValid),  32'h1);

`ifdef RV_BIMM_EN
    step(32'hFE20_8EE3, 1'b1);  // beq x1,x2,-4
    chk("beq.imm13B",    32'(orImm13B), 32'h1FFC);
    chk("beq.imm13BExt", orImm13BExt,   32'hFFFF_FFFC);
    step(32'h0000_0000, 1'b0);
    chk("beq.hold",      32'(orImm13B), 32'h1FFC);
`endif

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
